// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time, fixed-latency, byte-masked data-memory responder with internal SRAM.
// Define DMEM_FAULT_EN to enable request fault checking; otherwise o_fault is 0 and addresses wrap.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_fault
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [31:0]       addr_reg, wdata_reg, rdata_reg;
  logic              ren_reg, wen_reg, fault_reg;
  logic [3:0]        mask_reg;
  logic              accept, access, do_write, req_fault;
  logic [31:0]       offset, load_data;
  logic [AW-1:0]     word_idx;
  logic [3:0][7:0]   rd_byte, lane_mask;

  assign o_req_ready = (state_reg == IDLE) || (state_reg == RESP);
  assign o_rsp_valid = (state_reg == RESP);
  assign o_rdata     = rdata_reg;
  assign o_fault     = fault_reg;

  assign accept   = i_req_valid && o_req_ready;
  assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign offset   = addr_reg - BASE_ADDR;
  assign word_idx = offset[AW+1:2];

`ifdef DMEM_FAULT_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  // Subtracting first makes addresses below BASE_ADDR wrap high and fail the span test.
  assign req_fault = (ren_reg && wen_reg) ||
                     (addr_reg[1:0] != 2'b00) ||
                     ({1'b0, offset} >= SPAN) ||
                     ((mask_reg == 4'h0) && (ren_reg || wen_reg));
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
  assign req_fault = 1'b0;
`endif

  assign do_write  = access && wen_reg && !req_fault;
  assign load_data = (ren_reg && !wen_reg && !req_fault) ? (rd_byte & lane_mask) : 32'h0;

  // One byte-wide array per lane so masked stores map onto plain per-lane write enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
      if (do_write && mask_reg[gi])
        mem[word_idx] <= wdata_reg[8*gi +: 8];
    end

    assign rd_byte[gi]   = mem[word_idx];
    assign lane_mask[gi] = {8{mask_reg[gi]}};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = 4'(LATENCY - 1);
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        else                 state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      ren_reg   <= 1'b0;
      wen_reg   <= 1'b0;
      mask_reg  <= 4'h0;
      rdata_reg <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= i_addr;
        wdata_reg <= i_wdata;
        ren_reg   <= i_ren;
        wen_reg   <= i_wen;
        mask_reg  <= i_mask;
      end
      if (access) begin
        rdata_reg <= load_data;
        fault_reg <= req_fault;
      end
    end
  end
endmodule
